imm_extend_pipe: RTL and testbench

- Parametrised, registered immediate-extension stage for the MIPS datapath, sitting between instruction decode and the ALU operand mux.
- Generalises the combinational 16→32 sign/zero extender in three ways:
  - configurable input and output widths;
  - additional modes: LUI upper placement and branch word-offset shift;
  - valid/ready handshake with a 2-entry skid buffer and a synchronous flush for pipeline squash.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/imm_extend_core.sv | 48 ++++
 rtl/imm_extend_pipe.sv | 129 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: immediate-carrying opcodes,
// extension mode encoding and skid-buffer state encoding.
package mips_pkg;

    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BLEZ = 6'h06;
    localparam logic [5:0] OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_XORI = 6'h0e;
    localparam logic [5:0] OP_LUI  = 6'h0f;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'd0,
        MODE_ZERO   = 2'd1,
        MODE_UPPER  = 2'd2,
        MODE_BRANCH = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: opcode selects the mode,
// ports: opcode_i, imm_i in; mode_o, val_o out.
module imm_extend_core
    import mips_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic [5:0]           opcode_i,
    input  logic [IN_WIDTH-1:0]  imm_i,
    output mode_e                mode_o,
    output logic [OUT_WIDTH-1:0] val_o
);

    logic [OUT_WIDTH-1:0] sext;
    logic [OUT_WIDTH-1:0] zext;

    // Size cast of a signed operand sign-extends; also legal
    // when the widths are equal (no replication of zero bits).
    assign sext = OUT_WIDTH'($signed(imm_i));
    assign zext = OUT_WIDTH'(imm_i);

    always_comb begin
        mode_o = MODE_SIGN;
        unique case (opcode_i)
            OP_ANDI, OP_ORI, OP_XORI:
                mode_o = MODE_ZERO;
            OP_LUI:
                mode_o = MODE_UPPER;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                mode_o = MODE_BRANCH;
            default:
                mode_o = MODE_SIGN;
        endcase
    end

    always_comb begin
        val_o = sext;
        unique case (mode_o)
            MODE_SIGN:   val_o = sext;
            MODE_ZERO:   val_o = zext;
            MODE_UPPER:  val_o = zext << (OUT_WIDTH - IN_WIDTH);
            MODE_BRANCH: val_o = sext << 2;
            default:     val_o = sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer.
// Ports: clk, reset (async low), flush, in_* handshake, out_* handshake.
module imm_extend_pipe
    import mips_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_imm,
    input  logic [5:0]           in_opcode,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_val,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [1:0]           out_mode
);

    state_e               state_q, state_d;
    logic                 rdy_q, rdy_d;
    logic [OUT_WIDTH-1:0] mval_q, mval_d;
    logic [TAG_WIDTH-1:0] mtag_q, mtag_d;
    mode_e                mmode_q, mmode_d;
    logic [OUT_WIDTH-1:0] sval_q, sval_d;
    logic [TAG_WIDTH-1:0] stag_q, stag_d;
    mode_e                smode_q, smode_d;

    mode_e                cmode;
    logic [OUT_WIDTH-1:0] cval;
    logic                 acc_in;
    logic                 acc_out;

    imm_extend_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .opcode_i (in_opcode),
        .imm_i    (in_imm),
        .mode_o   (cmode),
        .val_o    (cval)
    );

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_val   = mval_q;
    assign out_tag   = mtag_q;
    assign out_mode  = mmode_q;

    assign acc_in  = in_valid && rdy_q;
    assign acc_out = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        mval_d  = mval_q;
        mtag_d  = mtag_q;
        mmode_d = mmode_q;
        sval_d  = sval_q;
        stag_d  = stag_q;
        smode_d = smode_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (acc_in) begin
                        mval_d  = cval;
                        mtag_d  = in_tag;
                        mmode_d = cmode;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc_in && acc_out) begin
                        mval_d  = cval;
                        mtag_d  = in_tag;
                        mmode_d = cmode;
                    end else if (acc_in) begin
                        sval_d  = cval;
                        stag_d  = in_tag;
                        smode_d = cmode;
                        state_d = ST_FULL;
                    end else if (acc_out) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (acc_out) begin
                        mval_d  = sval_q;
                        mtag_d  = stag_q;
                        mmode_d = smode_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // Registered ready looks only at the next buffer state.
        rdy_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b0;
            mval_q  <= '0;
            mtag_q  <= '0;
            mmode_q <= MODE_SIGN;
            sval_q  <= '0;
            stag_q  <= '0;
            smode_q <= MODE_SIGN;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            mval_q  <= mval_d;
            mtag_q  <= mtag_d;
            mmode_q <= mmode_d;
            sval_q  <= sval_d;
            stag_q  <= stag_d;
            smode_q <= smode_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe: queue-based reference model plus
// directed literal cases for both 16/32 and 8/16 configurations.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [5:0]  in_opcode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_val;
    logic [4:0]  out_tag;
    logic [1:0]  out_mode;

    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  in_imm2;
    logic [5:0]  in_opcode2;
    logic [4:0]  in_tag2;
    logic        out_valid2;
    logic        out_ready2;
    logic [15:0] out_val2;
    logic [4:0]  out_tag2;
    logic [1:0]  out_mode2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_opcode(in_opcode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_val(out_val), .out_tag(out_tag), .out_mode(out_mode)
    );

    imm_extend_pipe #(.IN_WIDTH(8), .OUT_WIDTH(16), .TAG_WIDTH(5)) dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_imm(in_imm2), .in_opcode(in_opcode2), .in_tag(in_tag2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_val(out_val2), .out_tag(out_tag2), .out_mode(out_mode2)
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int ref_mode(int op);
        if (op inside {'h0c, 'h0d, 'h0e}) return 1;
        if (op == 'h0f) return 2;
        if (op inside {'h04, 'h05, 'h06, 'h07}) return 3;
        return 0;
    endfunction

    // Arithmetic definition: signed value of the field, then
    // reduced modulo 2^outw.
    function automatic longint ref_val(longint imm, int op,
                                       int inw, int outw);
        longint mask;
        longint s;
        mask = (longint'(1) << outw) - 1;
        s = ((imm >> (inw - 1)) & 1) != 0 ?
            imm - (longint'(1) << inw) : imm;
        case (ref_mode(op))
            0:       return s & mask;
            1:       return imm;
            2:       return (imm * (longint'(1) << (outw - inw))) & mask;
            default: return (s * 4) & mask;
        endcase
    endfunction

    typedef struct {
        longint v;
        int     t;
        int     m;
    } exp_t;

    exp_t q[$];
    bit   ir_exp;

    // Reference: a FIFO of at most two entries.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            ir_exp = 1'b0;
        end else if (flush) begin
            q.delete();
            ir_exp = 1'b1;
        end else begin
            bit   ai;
            bit   ao;
            exp_t e;
            ai = in_valid && ir_exp;
            ao = (q.size() > 0) && out_ready;
            if (ao) void'(q.pop_front());
            if (ai) begin
                e.v = ref_val(longint'(in_imm), int'(in_opcode), 16, 32);
                e.t = int'(in_tag);
                e.m = ref_mode(int'(in_opcode));
                q.push_back(e);
            end
            ir_exp = (q.size() < 2);
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(ir_exp));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_val", 64'(out_val), 64'(q[0].v));
            chk("out_tag", 64'(out_tag), 64'(q[0].t));
            chk("out_mode", 64'(out_mode), 64'(q[0].m));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, logic [15:0] imm, logic [5:0] op,
                         logic [4:0] tg);
        in_valid  = v;
        in_imm    = imm;
        in_opcode = op;
        in_tag    = tg;
    endtask

    logic [15:0] lit_imm [4] = '{16'h8000, 16'h8000, 16'h8000, 16'hFFFF};
    logic [5:0]  lit_op  [4] = '{6'h08, 6'h0d, 6'h0f, 6'h04};
    logic [31:0] lit_val [4] = '{32'hFFFF8000, 32'h00008000,
                                 32'h80000000, 32'hFFFFFFFC};
    logic [5:0]  ops     [12] = '{6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                                  6'h04, 6'h05, 6'h06, 6'h07, 6'h23,
                                  6'h00, 6'h3f};
    logic [5:0]  op2     [3] = '{6'h08, 6'h0f, 6'h04};
    logic [15:0] val2    [3] = '{16'hFF80, 16'h8000, 16'hFE00};

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, '0);
        in_valid2 = 1'b0;
        in_imm2 = '0;
        in_opcode2 = '0;
        in_tag2 = '0;
        out_ready2 = 1'b1;

        chk("pin_sign", 64'(ref_val('h8000, 'h08, 16, 32)), 64'hFFFF8000);
        chk("pin_upper", 64'(ref_val('h8000, 'h0f, 16, 32)), 64'h80000000);
        chk("pin_br", 64'(ref_val('hFFFF, 'h04, 16, 32)), 64'hFFFFFFFC);
        chk("pin_br8", 64'(ref_val('h80, 'h04, 8, 16)), 64'hFE00);

        step();
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        step();
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        // Directed mode values.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, lit_imm[i], lit_op[i], 5'(i));
            step();
            chk("lit_val", 64'(out_val), 64'(lit_val[i]));
            chk("lit_mode", 64'(out_mode), 64'(i));
        end
        drive(1'b0, '0, '0, '0);
        step();

        // Back-to-back stream.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'($urandom), ops[$urandom_range(0, 11)], 5'(i));
            step();
            chk("stream_tag", 64'(out_tag), 64'(i));
            chk("stream_rdy", 64'(in_ready), 64'd1);
        end
        drive(1'b0, '0, '0, '0);
        step();

        // Backpressure: three offered, two taken.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(16'h1000 * (i + 1)), 6'h08, 5'(20 + i));
            step();
        end
        chk("bp_full_rdy", 64'(in_ready), 64'd0);
        chk("bp_head", 64'(out_tag), 64'd20);
        step();
        chk("bp_stable", 64'(out_val), 64'h3000 - 64'h2000);
        out_ready = 1'b1;
        step();
        chk("bp_second", 64'(out_tag), 64'd21);
        chk("bp_rdy_back", 64'(in_ready), 64'd1);
        drive(1'b0, '0, '0, '0);
        repeat (3) step();

        // Flush from FULL with a concurrent offer.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'h0042, 6'h0d, 5'(10 + i));
            step();
        end
        flush = 1'b1;
        drive(1'b1, 16'h0077, 6'h0d, 5'd31);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_rdy", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) step();

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'hABCD, 6'h0f, 5'(5 + i));
            step();
        end
        drive(1'b0, '0, '0, '0);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_val", 64'(out_val), 64'd0);
        chk("ar_tag", 64'(out_tag), 64'd0);
        chk("ar_mode", 64'(out_mode), 64'd0);
        chk("ar_rdy", 64'(in_ready), 64'd0);
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        step();
        drive(1'b1, 16'h0005, 6'h04, 5'd9);
        step();
        drive(1'b0, '0, '0, '0);
        chk("ar_lat_valid", 64'(out_valid), 64'd1);
        chk("ar_lat_val", 64'(out_val), 64'h14);
        step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom),
                  ops[$urandom_range(0, 11)], 5'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 24) == 0);
            step();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, '0);
        repeat (3) step();

        // Narrow configuration.
        for (int i = 0; i < 3; i++) begin
            in_valid2 = 1'b1;
            in_imm2 = 8'h80;
            in_opcode2 = op2[i];
            in_tag2 = 5'(i);
            step();
            chk("w8_valid", 64'(out_valid2), 64'd1);
            chk("w8_val", 64'(out_val2), 64'(val2[i]));
            chk("w8_tag", 64'(out_tag2), 64'(i));
        end
        in_valid2 = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
